// File: rtl/lf_stream_pkg.sv
// Shared types for the light-field pixel stream: framer FSM states and the
// marker bundle that downstream receivers decode.
package lf_stream_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} lf_state_e;

    localparam int PIXEL_W_DEFAULT = 24;

    typedef struct packed {
        logic soc;
        logic eoc;
        logic solf;
        logic eolf;
    } lf_markers_t;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lf_stream_framer_if.sv
// Upstream pixel handshake: a DMA/memory reader drives pixels, the framer accepts.
interface lf_stream_framer_if #(
    parameter int PIXEL_W = 24
);
    logic               src_valid;
    logic               src_ready;
    logic [PIXEL_W-1:0] src_pixel;

    modport master (output src_valid, output src_pixel, input  src_ready);
    modport slave  (input  src_valid, input  src_pixel, output src_ready);
endinterface

// File: rtl/lf_position_counter.sv
// Pixel-in-capture and capture-in-light-field position tracker with first/last
// flags; shared by the framer and by stream checkers.
module lf_position_counter
    import lf_stream_pkg::*;
#(
    parameter int PIX_TOTAL    = 8,
    parameter int NUM_CAPTURES = 3,
    parameter int CAP_CW       = $clog2(NUM_CAPTURES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              pix_inc,
    input  logic              cap_inc,
    output logic [CAP_CW-1:0] cap_idx,
    output logic              pix_first,
    output logic              pix_last,
    output logic              cap_first,
    output logic              cap_last
);
    localparam int PIX_CW = safe_clog2(PIX_TOTAL);

    logic [PIX_CW-1:0] pix_cnt;

    assign pix_first = (pix_cnt == '0);
    assign pix_last  = (pix_cnt == PIX_CW'(PIX_TOTAL - 1));
    assign cap_first = (cap_idx == '0);
    assign cap_last  = (cap_idx == CAP_CW'(NUM_CAPTURES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            cap_idx <= '0;
        end else if (clear) begin
            pix_cnt <= '0;
            cap_idx <= '0;
        end else begin
            if (pix_inc) pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
            if (cap_inc) cap_idx <= cap_idx + 1'b1;
        end
    end

endmodule

// File: rtl/lf_stream_framer.sv
// Source end of the light-field pixel stream: accepts raw pixels and emits them
// one cycle later with SOC/EOC/SOLF/EOLF framing and inter-capture idle gaps.
module lf_stream_framer
    import lf_stream_pkg::*;
#(
    parameter  int IMG_WIDTH    = 640,
    parameter  int IMG_HEIGHT   = 480,
    parameter  int NUM_CAPTURES = 17,
    parameter  int GAP_CYCLES   = 16,
    parameter  int PIXEL_W      = PIXEL_W_DEFAULT,
    localparam int CAP_CW       = $clog2(NUM_CAPTURES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    lf_stream_framer_if.slave   src,
    output logic                pixel_valid_out,
    output logic [PIXEL_W-1:0]  pixel_out,
    output logic                soc_out,
    output logic                eoc_out,
    output logic                solf_out,
    output logic                eolf_out,
    output logic                busy,
    output logic [CAP_CW-1:0]   capture_idx,
    output logic                done,
    output logic                aborted
);
    localparam int PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int GAP_CW    = safe_clog2(GAP_CYCLES + 1);

    lf_state_e         state, state_nxt;
    logic [GAP_CW-1:0] gap_cnt;
    logic              src_ready, accept, gap_end;
    logic              start_acc, pos_clr, cap_inc;
    logic              pix_first, pix_last, cap_first, cap_last;
    lf_markers_t       mk_d, mk_q;

    // Abort masks ready so a pixel offered alongside it is never taken.
    assign src_ready     = (state == STREAM) && !abort;
    assign src.src_ready = src_ready;
    assign accept        = src.src_valid && src_ready;
    assign start_acc     = (state == IDLE) && start && !abort;
    assign gap_end       = (gap_cnt == GAP_CW'(GAP_CYCLES - 1));
    assign busy          = (state != IDLE);
    assign pos_clr       = start_acc || (state_nxt == IDLE);

    lf_position_counter #(
        .PIX_TOTAL    (PIX_TOTAL),
        .NUM_CAPTURES (NUM_CAPTURES),
        .CAP_CW       (CAP_CW)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pos_clr),
        .pix_inc   (accept),
        .cap_inc   (cap_inc),
        .cap_idx   (capture_idx),
        .pix_first (pix_first),
        .pix_last  (pix_last),
        .cap_first (cap_first),
        .cap_last  (cap_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cap_inc   = 1'b0;
        unique case (state)
            IDLE:   if (start_acc) state_nxt = STREAM;
            STREAM: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept && pix_last) begin
                    if (cap_last)            state_nxt = DONE;
                    else if (GAP_CYCLES > 0) state_nxt = GAP;
                    else                     cap_inc   = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (gap_end) begin
                    state_nxt = STREAM;
                    cap_inc   = 1'b1;
                end
            end
            DONE:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              gap_cnt <= '0;
        else if (state == GAP)   gap_cnt <= gap_cnt + 1'b1;
        else                     gap_cnt <= '0;
    end

    // done trails the eolf pixel by one cycle; an abort in DONE suppresses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            done <= (state == DONE) && !abort;
            if (busy && abort)  aborted <= 1'b1;
            else if (start_acc) aborted <= 1'b0;
        end
    end

    always_comb begin
        mk_d = '0;
        if (accept) begin
            mk_d.soc  = pix_first;
            mk_d.eoc  = pix_last;
            mk_d.solf = pix_first && cap_first;
            mk_d.eolf = pix_last && cap_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_valid_out <= 1'b0;
            pixel_out       <= '0;
            mk_q            <= '0;
        end else begin
            pixel_valid_out <= accept;
            mk_q            <= mk_d;
            if (accept) pixel_out <= src.src_pixel;
        end
    end

    assign soc_out  = mk_q.soc;
    assign eoc_out  = mk_q.eoc;
    assign solf_out = mk_q.solf;
    assign eolf_out = mk_q.eolf;

endmodule

// File: tb/tb_lf_stream_framer.sv
// Three framers (gapped, gapless, single-pixel light field) share one random
// stimulus stream; an arithmetic stream model feeds per-DUT scoreboards.
module tb_lf_stream_framer;
    localparam int ND = 3;
    localparam int PT  [ND] = '{8, 8, 1};
    localparam int NCT [ND] = '{3, 3, 1};
    localparam int GT  [ND] = '{2, 0, 2};

    typedef struct packed {
        logic [23:0] pix;
        logic soc, eoc, solf, eolf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, src_valid = 1'b0;
    logic [23:0] src_pixel = '0;
    int          vmode = 3;

    always #5 clk = ~clk;

    lf_stream_framer_if #(.PIXEL_W(24)) sif0 ();
    lf_stream_framer_if #(.PIXEL_W(24)) sif1 ();
    lf_stream_framer_if #(.PIXEL_W(24)) sif2 ();
    assign sif0.src_valid = src_valid;
    assign sif1.src_valid = src_valid;
    assign sif2.src_valid = src_valid;
    assign sif0.src_pixel = src_pixel;
    assign sif1.src_pixel = src_pixel;
    assign sif2.src_pixel = src_pixel;

    logic [ND-1:0]       rdy, pv, soc, eoc, solf, eolf, busy, done, abd;
    logic [ND-1:0][23:0] pix;
    logic [1:0]          cidx0, cidx1;
    logic [0:0]          cidx2;
    assign rdy[0] = sif0.src_ready;
    assign rdy[1] = sif1.src_ready;
    assign rdy[2] = sif2.src_ready;

    lf_stream_framer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .NUM_CAPTURES(3), .GAP_CYCLES(2), .PIXEL_W(24)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .src(sif0),
        .pixel_valid_out(pv[0]), .pixel_out(pix[0]), .soc_out(soc[0]), .eoc_out(eoc[0]),
        .solf_out(solf[0]), .eolf_out(eolf[0]), .busy(busy[0]), .capture_idx(cidx0),
        .done(done[0]), .aborted(abd[0]));

    lf_stream_framer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .NUM_CAPTURES(3), .GAP_CYCLES(0), .PIXEL_W(24)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .src(sif1),
        .pixel_valid_out(pv[1]), .pixel_out(pix[1]), .soc_out(soc[1]), .eoc_out(eoc[1]),
        .solf_out(solf[1]), .eolf_out(eolf[1]), .busy(busy[1]), .capture_idx(cidx1),
        .done(done[1]), .aborted(abd[1]));

    lf_stream_framer #(.IMG_WIDTH(1), .IMG_HEIGHT(1), .NUM_CAPTURES(1), .GAP_CYCLES(2), .PIXEL_W(24)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .src(sif2),
        .pixel_valid_out(pv[2]), .pixel_out(pix[2]), .soc_out(soc[2]), .eoc_out(eoc[2]),
        .solf_out(solf[2]), .eolf_out(eolf[2]), .busy(busy[2]), .capture_idx(cidx2),
        .done(done[2]), .aborted(abd[2]));

    // Reference state: handshakes seen since start, pending gap cycles, flags.
    int   n [ND];
    int   mgap [ND];
    bit   mbusy [ND], fin [ND], mdone [ND], mab [ND];
    exp_t q0[$], q1[$], q2[$];
    int   nchk = 0, nerr = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic bit exp_rdy(input int k);
        return mbusy[k] && !fin[k] && (mgap[k] == 0) && !abort;
    endfunction

    function automatic int cidx(input int k);
        case (k)
            0:       return int'(cidx0);
            1:       return int'(cidx1);
            default: return int'(cidx2);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int k);
        exp_t e;
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        return e;
    endfunction

    function automatic void qpush(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic void qclear(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    // Monitor: compares what the DUTs present against the model each cycle.
    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (!rst_n) begin
                chk("rst_valid", k, pv[k], 0);
                chk("rst_pixel", k, pix[k], 0);
                chk("rst_markers", k, {soc[k], eoc[k], solf[k], eolf[k]}, 0);
                chk("rst_busy_done_abd_rdy", k, {busy[k], done[k], abd[k], rdy[k]}, 0);
            end else begin
                chk("src_ready", k, rdy[k], exp_rdy(k));
                chk("busy", k, busy[k], mbusy[k]);
                chk("done", k, done[k], mdone[k]);
                chk("aborted", k, abd[k], mab[k]);
                if (pv[k]) begin
                    if (qsize(k) == 0) begin
                        nchk++;
                        nerr++;
                        $display("FAIL unexpected_pixel dut%0d: got pixel %0h, expected none at %0t", k, pix[k], $time);
                    end else begin
                        exp_t e;
                        e = qpop(k);
                        chk("pixel", k, pix[k], e.pix);
                        chk("markers", k, {soc[k], eoc[k], solf[k], eolf[k]}, {e.soc, e.eoc, e.solf, e.eolf});
                    end
                end else begin
                    chk("idle_markers", k, {soc[k], eoc[k], solf[k], eolf[k]}, 0);
                end
            end
        end
    end

    // Model: predicts the coming clock edge from the stimulus now on the pins.
    always begin
        @(negedge clk);
        #2;
        for (int k = 0; k < ND; k++) begin
            if (!rst_n) begin
                n[k] = 0; mgap[k] = 0; mbusy[k] = 0; fin[k] = 0; mdone[k] = 0; mab[k] = 0;
                qclear(k);
            end else begin
                bit   hs;
                exp_t e;
                hs = src_valid && exp_rdy(k);
                mdone[k] = 0;
                if (mgap[k] > 0) mgap[k]--;
                if (fin[k]) begin
                    fin[k] = 0;
                    mbusy[k] = 0;
                    if (abort) mab[k] = 1;
                    else       mdone[k] = 1;
                end else if (mbusy[k] && abort) begin
                    mbusy[k] = 0;
                    mab[k] = 1;
                    mgap[k] = 0;
                end else if (mbusy[k] && hs) begin
                    chk("capture_idx", k, cidx(k), n[k] / PT[k]);
                    e.pix  = src_pixel;
                    e.soc  = (n[k] % PT[k]) == 0;
                    e.eoc  = (n[k] % PT[k]) == PT[k] - 1;
                    e.solf = (n[k] == 0);
                    e.eolf = (n[k] == PT[k] * NCT[k] - 1);
                    qpush(k, e);
                    n[k]++;
                    if (n[k] == PT[k] * NCT[k]) fin[k] = 1;
                    else if (n[k] % PT[k] == 0) mgap[k] = GT[k];
                end else if (!mbusy[k] && start && !abort) begin
                    mbusy[k] = 1;
                    n[k] = 0;
                    mab[k] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        src_pixel = 24'($urandom());
        case (vmode)
            0:       src_valid = 1'b1;
            1:       src_valid = ($urandom_range(0, 9) < 6);
            2:       src_valid = ~src_valid;
            default: src_valid = 1'b0;
        endcase
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((mbusy[0] || mbusy[1] || mbusy[2]) && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) begin
            nchk++;
            nerr++;
            $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", budget);
        end
        repeat (3) tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        // continuous, bubbles toggling, random bubbles
        vmode = 0; pulse_start(); wait_idle(200);
        vmode = 2; pulse_start(); wait_idle(300);
        vmode = 1; pulse_start(); wait_idle(300);

        // start and abort together while idle: start is dropped
        vmode = 0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (4) tick();

        // abort after 10 pixels, then restart
        pulse_start();
        for (int c = 0; c < 100 && n[0] < 10; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        pulse_start();
        wait_idle(200);

        // starts while busy, then async reset in capture 1
        vmode = 1;
        pulse_start();
        for (int i = 0; i < 80 && !(mbusy[0] && n[0] >= 11); i++) begin
            start = (i % 5 == 4);
            tick();
        end
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk("async_rst_valid", k, pv[k], 0);
            chk("async_rst_markers", k, {soc[k], eoc[k], solf[k], eolf[k]}, 0);
            chk("async_rst_busy_rdy", k, {busy[k], rdy[k], done[k], abd[k]}, 0);
        end
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        vmode = 0;
        pulse_start();
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
